// File: rtl/sd_rrarb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_rrarb_pkg
// Description : Shared constants and grant helpers for the round-robin mux.
// Revision    : 1.0
// ============================================================================
package sd_rrarb_pkg;

    localparam int c_max_inputs = 16;
    localparam int c_idx_w      = $clog2(c_max_inputs);

    function automatic logic [c_max_inputs-1:0] idx_to_onehot(input logic [c_idx_w-1:0] idx);
        idx_to_onehot      = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : sd_rr_pick
// Description : Combinational round-robin picker; one-hot winner from requests.
// Revision    : 1.0
// ============================================================================
module sd_rr_pick
    import sd_rrarb_pkg::*;
#(
    parameter int inputs = 4,
    localparam int c_gw  = $clog2(inputs)
) (
    input  logic [inputs-1:0] i_req,
    input  logic [c_gw-1:0]   i_last_grant,
    output logic [inputs-1:0] o_grant
);

    logic [c_gw-1:0] w_sel;
    logic            w_found;

    // Scan starts one past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= inputs; k++) begin
            w_sel = c_gw'((int'(i_last_grant) + k) % inputs);
            if (!w_found && i_req[w_sel]) begin
                o_grant = inputs'(idx_to_onehot(c_idx_w'(w_sel)));
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_rrarb_mux.sv
`default_nettype none
// ============================================================================
// Module      : sd_rrarb_mux
// Description : Round-robin arbiter/mux of srdy/drdy channels into one
//               registered output. SD_RRARB_PKTLOCK_EN enables packet locking.
// Revision    : 1.0
// ============================================================================
module sd_rrarb_mux
    import sd_rrarb_pkg::*;
#(
    parameter int width  = 8,
    parameter int inputs = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [inputs-1:0]       c_srdy,
    output logic [inputs-1:0]       c_drdy,
    input  logic [inputs*width-1:0] c_data,
    input  logic [inputs-1:0]       c_eop,
    output logic                    p_srdy,
    input  logic                    p_drdy,
    output logic [width-1:0]        p_data,
    output logic                    p_eop,
    output logic [inputs-1:0]       p_grant
);

    localparam int              c_gw       = $clog2(inputs);
    localparam logic [c_gw-1:0] c_last_rst = c_gw'(inputs - 1);

    logic                r_p_srdy;
    logic [width-1:0]    r_p_data;
    logic                r_p_eop;
    logic [inputs-1:0]   r_p_grant;
    logic [c_gw-1:0]     r_last_grant;

    logic                w_ld;
    logic [inputs-1:0]   w_elig;
    logic [inputs-1:0]   w_req;
    logic [inputs-1:0]   w_pick;
    logic [inputs-1:0]   w_grant_ok;
    logic                w_xfer;
    logic [width-1:0]    w_win_data;
    logic                w_win_eop;
    logic [c_gw-1:0]     w_win_idx;

`ifdef SD_RRARB_PKTLOCK_EN
    logic r_locked;

    // The locked channel is always the last winner, so no separate owner register is needed.
    assign w_elig = r_locked ? inputs'(idx_to_onehot(c_idx_w'(r_last_grant))) : '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_locked <= 1'b0;
        end else if (w_xfer) begin
            r_locked <= !w_win_eop;
        end
    end
`else
    assign w_elig = '1;
`endif

    assign w_ld       = !r_p_srdy || p_drdy;
    assign w_req      = c_srdy & w_elig;
    assign w_grant_ok = w_ld ? w_pick : '0;
    assign w_xfer     = |w_grant_ok;
    assign c_drdy     = reset ? w_grant_ok : '0;

    sd_rr_pick #(
        .inputs       (inputs)
    ) u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick)
    );

    always_comb begin
        w_win_data = '0;
        w_win_eop  = 1'b0;
        w_win_idx  = '0;
        for (int i = 0; i < inputs; i++) begin
            if (w_pick[i]) begin
                w_win_data = c_data[i*width +: width];
                w_win_eop  = c_eop[i];
                w_win_idx  = c_gw'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p_srdy     <= 1'b0;
            r_p_data     <= '0;
            r_p_eop      <= 1'b0;
            r_p_grant    <= '0;
            r_last_grant <= c_last_rst;
        end else if (w_xfer) begin
            r_p_srdy     <= 1'b1;
            r_p_data     <= w_win_data;
            r_p_eop      <= w_win_eop;
            r_p_grant    <= w_pick;
            r_last_grant <= w_win_idx;
        end else if (r_p_srdy && p_drdy) begin
            r_p_srdy     <= 1'b0;
        end
    end

    assign p_srdy  = r_p_srdy;
    assign p_data  = r_p_data;
    assign p_eop   = r_p_eop;
    assign p_grant = r_p_grant;

endmodule
`default_nettype wire

// File: tb/tb_sd_rrarb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_rrarb_mux
// Description : Self-checking bench for sd_rrarb_mux (4 channels x 8 bits).
// Revision    : 1.0
// ============================================================================
module tb_sd_rrarb_mux;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  c_srdy = '0;
    logic [3:0]  c_drdy;
    logic [31:0] c_data = '0;
    logic [3:0]  c_eop  = '0;
    logic        p_srdy;
    logic        p_drdy = 1'b0;
    logic [7:0]  p_data;
    logic        p_eop;
    logic [3:0]  p_grant;

    int n_pass  = 0;
    int n_total = 0;

    sd_rrarb_mux #(.width(8), .inputs(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .c_srdy  (c_srdy),
        .c_drdy  (c_drdy),
        .c_data  (c_data),
        .c_eop   (c_eop),
        .p_srdy  (p_srdy),
        .p_drdy  (p_drdy),
        .p_data  (p_data),
        .p_eop   (p_eop),
        .p_grant (p_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic [3:0] s, input logic [31:0] d, input logic [3:0] e, input logic dr);
        c_srdy = s;
        c_data = d;
        c_eop  = e;
        p_drdy = dr;
    endtask

    // Called at posedge+1: apply inputs, check c_drdy, then check registered outputs after the edge.
    task automatic step(input string nm, input logic [3:0] s, input logic [31:0] d, input logic [3:0] e,
                        input logic dr, input logic [3:0] xcd, input logic xs, input logic [3:0] xg,
                        input logic [7:0] xd, input logic xe);
        drive(s, d, e, dr);
        #1;
        check({nm, "_cdrdy"}, {28'd0, c_drdy}, {28'd0, xcd});
        @(posedge clk);
        #1;
        check({nm, "_out"}, {18'd0, p_srdy, p_eop, p_grant, p_data}, {18'd0, xs, xe, xg, xd});
    endtask

    // Reference model: last winner index, output word, lock flag.
    int         m_last;
    bit         m_srdy, m_eop, m_lock;
    logic [7:0] m_data;
    logic [3:0] m_grant, m_acc;

    task automatic model_reset();
        m_last  = 3;
        m_srdy  = 0;
        m_eop   = 0;
        m_lock  = 0;
        m_data  = '0;
        m_grant = '0;
        m_acc   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'b1111, 32'h44332211, 4'b0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {18'd0, c_drdy, p_srdy, p_eop, p_grant, p_data}, 32'd0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic model_cycle();
        int win;
        check("rand_out", {18'd0, p_srdy, p_eop, p_grant, p_data}, {18'd0, m_srdy, m_eop, m_grant, m_data});
        win = -1;
        if (!m_srdy || p_drdy) begin
            for (int k = 1; k <= 4; k++) begin
                int ch;
                ch = (m_last + k) % 4;
                if (win < 0 && c_srdy[ch] && (!m_lock || ch == m_last)) win = ch;
            end
        end
        m_acc = (win >= 0) ? 4'(1 << win) : 4'd0;
        check("rand_cdrdy", {28'd0, c_drdy}, {28'd0, m_acc});
        if (win >= 0) begin
            m_srdy  = 1;
            m_data  = c_data[win*8 +: 8];
            m_eop   = c_eop[win];
            m_grant = m_acc;
            m_last  = win;
`ifdef SD_RRARB_PKTLOCK_EN
            m_lock  = !c_eop[win];
`endif
        end else if (m_srdy && p_drdy) begin
            m_srdy = 0;
        end
    endtask

    // Handshake monitor on both ports, sampled on the falling edge.
    logic       h_v = 1'b0, h_srdy = 1'b0, h_drdy = 1'b0, h_eop = 1'b0;
    logic [3:0] h_grant = '0;
    logic [7:0] h_data  = '0;
    bit         rst_evt = 0;

    always @(negedge reset) rst_evt = 1'b1;

    always @(negedge clk) begin
        if (reset && h_v && !rst_evt && h_srdy && !h_drdy)
            check("hold", {18'd0, p_srdy, p_eop, p_grant, p_data}, {18'd0, 1'b1, h_eop, h_grant, h_data});
        if (reset) begin
            check("cdrdy_onehot0", 32'($onehot0(c_drdy)), 32'd1);
            if (p_srdy && !p_drdy) check("cdrdy_gated", {28'd0, c_drdy}, 32'd0);
        end
        h_v     = reset;
        h_srdy  = p_srdy;
        h_drdy  = p_drdy;
        h_eop   = p_eop;
        h_grant = p_grant;
        h_data  = p_data;
        rst_evt = 0;
    end

    typedef struct {
        logic        rst_first;
        logic [3:0]  srdy;
        logic [31:0] data;
        logic        dr;
        logic [3:0]  x_cdrdy;
        logic        x_psrdy;
        logic [3:0]  x_grant;
        logic [7:0]  x_data;
    } vec_t;

    vec_t tbl[14];

    initial begin
        localparam logic [31:0] D = 32'h44332211;
        localparam logic [31:0] A = 32'h00A50000;
        // Full rotation, then alternating pair, then a stalled single requester.
        tbl[0]  = '{1'b1, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11};
        tbl[1]  = '{1'b0, 4'b1111, D, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22};
        tbl[2]  = '{1'b0, 4'b1111, D, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'h33};
        tbl[3]  = '{1'b0, 4'b1111, D, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44};
        tbl[4]  = '{1'b0, 4'b1111, D, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11};
        tbl[5]  = '{1'b1, 4'b1010, D, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22};
        tbl[6]  = '{1'b0, 4'b1010, D, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44};
        tbl[7]  = '{1'b0, 4'b1010, D, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22};
        tbl[8]  = '{1'b0, 4'b0000, D, 1'b1, 4'b0000, 1'b0, 4'b0010, 8'h22};
        tbl[9]  = '{1'b1, 4'b0100, A, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'hA5};
        tbl[10] = '{1'b0, 4'b0100, A, 1'b0, 4'b0000, 1'b1, 4'b0100, 8'hA5};
        tbl[11] = '{1'b0, 4'b0100, A, 1'b0, 4'b0000, 1'b1, 4'b0100, 8'hA5};
        tbl[12] = '{1'b0, 4'b0100, A, 1'b0, 4'b0000, 1'b1, 4'b0100, 8'hA5};
        tbl[13] = '{1'b0, 4'b0000, A, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'hA5};

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst_first) do_reset();
            step($sformatf("vec%0d", i), tbl[i].srdy, tbl[i].data, 4'b0000, tbl[i].dr,
                 tbl[i].x_cdrdy, tbl[i].x_psrdy, tbl[i].x_grant, tbl[i].x_data, 1'b0);
        end

        // Asynchronous reset while a word is stalled on the output.
        do_reset();
        step("midrst_load", 4'b0100, A, 4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0100, 8'hA5, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("midrst_out", {18'd0, c_drdy, p_srdy, p_eop, p_grant, p_data}, 32'd0);
        #1 reset = 1'b1;
        step("midrst_next", 4'b1111, D, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11, 1'b0);

`ifdef SD_RRARB_PKTLOCK_EN
        do_reset();
        step("lock_w0",   4'b0010, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22, 1'b0);
        step("lock_drop", 4'b1001, D, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0010, 8'h22, 1'b0);
        step("lock_w1",   4'b1011, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22, 1'b0);
        step("lock_w2",   4'b1011, D, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22, 1'b1);
        step("lock_ch3",  4'b1001, D, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44, 1'b0);
        step("lock_ch0",  4'b1001, D, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11, 1'b0);
`else
        do_reset();
        step("word_w0",  4'b0010, D, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22, 1'b0);
        step("word_ch3", 4'b1011, D, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44, 1'b0);
        step("word_ch0", 4'b1011, D, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11, 1'b1);
`endif

        // Randomized traffic; sources hold srdy and data until accepted.
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (!(c_srdy[ch] && !m_acc[ch])) begin
                    c_srdy[ch]        = ($urandom_range(0, 2) != 0);
                    c_data[ch*8 +: 8] = 8'($urandom);
                    c_eop[ch]         = ($urandom_range(0, 2) == 0);
                end
            end
            p_drdy = ($urandom_range(0, 3) != 0);
            #1;
            model_cycle();
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_rrarb_mux.md
SD_RRARB_MUX -- requirements
Module: sd_rrarb_mux

Interface
REQ-001 The module SHALL have parameter width, default 8, meaning bits per data word.
REQ-002 The module SHALL have parameter inputs, default 4, meaning number of requesting channels (2..16).
REQ-003 Port clk  input  1  the only clock; all state changes on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 Port c_srdy  input  inputs  per-channel source-ready.
REQ-006 Port c_drdy  output  inputs  per-channel destination-ready; at most one bit set per cycle.
REQ-007 Port c_data  input  inputs*width  channel i data at bits [i*width +: width].
REQ-008 Port c_eop  input  inputs  per-channel end-of-packet marker qualifying c_data.
REQ-009 Port p_srdy  output  1  output word valid.
REQ-010 Port p_drdy  input  1  downstream accepts.
REQ-011 Port p_data  output  width  registered output word.
REQ-012 Port p_eop  output  1  registered eop of p_data.
REQ-013 Port p_grant  output  inputs  registered one-hot index of the channel that sourced p_data.

Function
REQ-014 A channel transfer SHALL occur when c_srdy[i] && c_drdy[i]; an output transfer when p_srdy && p_drdy.
REQ-015 Load condition SHALL be ld = (!p_srdy || p_drdy); c_drdy SHALL be all-zero when ld is 0.
REQ-016 When ld is 1, c_drdy SHALL be one-hot on the round-robin winner among eligible requesting channels, else zero.
REQ-017 Round-robin order SHALL start at index (last_grant+1) mod inputs and wrap to 0.
REQ-018 last_grant SHALL update only on a channel transfer.
REQ-019 On a channel transfer the output register SHALL load c_data, c_eop and grant of the winner and set p_srdy the next cycle (latency 1).
REQ-020 On an output transfer with no channel transfer, p_srdy SHALL clear next cycle.
REQ-021 Simultaneous output and channel transfer SHALL reload the register with p_srdy staying 1 (one word/cycle throughput).
REQ-022 While p_srdy && !p_drdy, p_data, p_eop, p_grant SHALL hold.
REQ-023 c_drdy SHALL not depend combinationally on p_data or c_data.
REQ-024 A single continuously requesting channel with p_drdy=1 SHALL transfer every cycle.
REQ-025 No requesters SHALL leave last_grant and output register unchanged apart from REQ-020.

Reset
REQ-026 While reset=0: p_srdy=0, p_data=0, p_eop=0, p_grant=0, c_drdy=0, last_grant=inputs-1 (channel 0 highest priority first), lock cleared.
REQ-027 Reset mid-transfer SHALL discard the held word; no partial state survives.

Configuration
REQ-028 Macro SD_RRARB_PKTLOCK_EN SHALL enable packet locking: after a channel transfer with c_eop=0 from channel i, only channel i is eligible until a transfer from i with c_eop=1.
REQ-029 With SD_RRARB_PKTLOCK_EN defined, a locked channel deasserting c_srdy SHALL not release the lock; c_drdy stays zero for others.
REQ-030 Without SD_RRARB_PKTLOCK_EN, c_eop SHALL only be carried to p_eop and arbitration SHALL be per-word.

Structure
REQ-031 Package sd_rrarb_pkg SHALL hold the max-inputs constant and a grant-index-to-one-hot function.
REQ-032 Combinational sub-module sd_rr_pick SHALL compute the one-hot winner from request vector and last_grant; all state SHALL be in sd_rrarb_mux.

Verification
REQ-033 inputs=4, c_srdy=4'b1111 constant, p_drdy=1 -> p_grant sequence 0001,0010,0100,1000,0001, p_srdy continuous.
REQ-034 Only c_srdy[2]=1, c_data ch2=8'hA5, p_drdy=0 for 3 cycles -> p_data=8'hA5 held 3 cycles, c_drdy=0 while held.
REQ-035 c_srdy=4'b1010 after reset, p_drdy=1 -> grants 0010,1000,0010 alternating.
REQ-036 SD_RRARB_PKTLOCK_EN, ch1 sends 3 words eop=0,0,1 while ch0,ch3 request -> ch1 words contiguous on p_data, then ch3, then ch0.
REQ-037 reset=0 pulsed while p_srdy=1 and p_drdy=0 -> p_srdy=0 immediately, next grant 0001 if ch0 requests.
REQ-038 Every run SHALL check on both ports: srdy held until drdy and data stable while srdy && !drdy.
